// File: rtl/pci_mem_bridge.sv
// Single-beat command port to AXI master bridge: each command becomes one 32-bit
// AXI write or read, with a response-wait timeout and draining of late responses.
module pci_mem_bridge #(
    parameter logic [15:0] ID_VAL      = 16'd0,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_we,
    input  logic [63:0]  cmd_addr,
    input  logic [31:0]  cmd_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [31:0]  rsp_rdata,
    output logic [1:0]   rsp_err,
    output logic         busy,
    output logic [15:0]  m_awid,
    output logic [63:0]  m_awaddr,
    output logic [7:0]   m_awlen,
    output logic [2:0]   m_awsize,
    output logic         m_awvalid,
    input  logic         m_awready,
    output logic [15:0]  m_wid,
    output logic [511:0] m_wdata,
    output logic [63:0]  m_wstrb,
    output logic         m_wlast,
    output logic         m_wvalid,
    input  logic         m_wready,
    input  logic [15:0]  m_bid,
    input  logic [1:0]   m_bresp,
    input  logic         m_bvalid,
    output logic         m_bready,
    output logic [15:0]  m_arid,
    output logic [63:0]  m_araddr,
    output logic [7:0]   m_arlen,
    output logic [2:0]   m_arsize,
    output logic         m_arvalid,
    input  logic         m_arready,
    input  logic [15:0]  m_rid,
    input  logic [511:0] m_rdata,
    input  logic [1:0]   m_rresp,
    input  logic         m_rlast,
    input  logic         m_rvalid,
    output logic         m_rready
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN} state_t;

    localparam logic [15:0] WaitLimit = 16'(TIMEOUT_CYC - 1);

    state_t       state_q, state_d;
    logic         we_q, we_d;
    logic [63:2]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic         aw_done_q, aw_done_d;
    logic         w_done_q, w_done_d;
    logic         drain_q, drain_d;
    logic [15:0]  wait_q, wait_d;
    logic [31:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]   rsp_err_q, rsp_err_d;
    logic         cmd_ready_q, busy_q, rsp_valid_q;
    logic         awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic         aw_fire, w_fire;
    logic         unused_inputs;

    assign aw_fire = awvalid_q & m_awready;
    assign w_fire  = wvalid_q & m_wready;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        drain_d     = drain_q;
        wait_d      = wait_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d      = cmd_we;
                    addr_d    = cmd_addr[63:2];
                    wdata_d   = cmd_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_we ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                    wait_d  = 16'd0;
                end
            end
            RD_REQ: begin
                if (m_arready) begin
                    state_d = RD_RESP;
                    wait_d  = 16'd0;
                end
            end
            // A response seen in the timeout cycle takes priority over the timeout.
            WR_RESP: begin
                if (m_bvalid) begin
                    state_d     = RSP;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = (m_bresp != 2'b00) ? 2'b01 : 2'b00;
                end else if (wait_q == WaitLimit) begin
                    state_d     = RSP;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 2'b11;
                    drain_d     = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RD_RESP: begin
                if (m_rvalid) begin
                    if (m_rlast) begin
                        state_d     = RSP;
                        rsp_rdata_d = m_rdata[{addr_q[5:2], 5'd0} +: 32];
                        rsp_err_d   = (m_rresp != 2'b00) ? 2'b01 : 2'b00;
                    end
                end else if (wait_q == WaitLimit) begin
                    state_d     = RSP;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 2'b11;
                    drain_d     = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = drain_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (we_q ? m_bvalid : (m_rvalid && m_rlast)) begin
                    drain_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next-state values so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            drain_q     <= 1'b0;
            wait_q      <= 16'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 2'b00;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            drain_q     <= drain_d;
            wait_q      <= wait_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            rsp_valid_q <= (state_d == RSP);
            awvalid_q   <= (state_d == WR_REQ) && !aw_done_d;
            wvalid_q    <= (state_d == WR_REQ) && !w_done_d;
            arvalid_q   <= (state_d == RD_REQ);
            bready_q    <= (state_d == WR_RESP) || (state_d == DRAIN);
            rready_q    <= (state_d == RD_RESP) || (state_d == DRAIN);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign m_awid    = ID_VAL;
    assign m_awaddr  = {addr_q, 2'b00};
    assign m_awlen   = 8'd0;
    assign m_awsize  = 3'b010;
    assign m_awvalid = awvalid_q;
    assign m_wid     = ID_VAL;
    assign m_wdata   = {16{wdata_q}};
    assign m_wstrb   = 64'hF << {addr_q[5:2], 2'b00};
    assign m_wlast   = 1'b1;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arid    = ID_VAL;
    assign m_araddr  = {addr_q, 2'b00};
    assign m_arlen   = 8'd0;
    assign m_arsize  = 3'b010;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

    assign unused_inputs = ^{m_bid, m_rid, cmd_addr[1:0]};
endmodule

// File: tb/tb_pci_mem_bridge.sv
// Bench for pci_mem_bridge: directed vector table, reset corner case and randomized
// transactions, all driven through a small AXI slave model with per-transaction timing.
module tb_pci_mem_bridge;
    localparam int unsigned TO = 8;
    localparam logic [15:0] ID = 16'h05A3;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
    logic [63:0]  cmd_addr = '0;
    logic [31:0]  cmd_wdata = '0;
    logic         cmd_ready, rsp_valid, busy;
    logic [31:0]  rsp_rdata;
    logic [1:0]   rsp_err;
    logic [15:0]  m_awid, m_wid, m_arid;
    logic [63:0]  m_awaddr, m_araddr, m_wstrb;
    logic [7:0]   m_awlen, m_arlen;
    logic [2:0]   m_awsize, m_arsize;
    logic         m_awvalid, m_wvalid, m_wlast, m_arvalid, m_bready, m_rready;
    logic [511:0] m_wdata;
    logic         m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic         m_bvalid = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
    logic [1:0]   m_bresp = '0, m_rresp = '0;
    logic [15:0]  m_bid = '0, m_rid = '0;
    logic [511:0] m_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [31:0] wdata;
        int          awDly;
        int          wDly;
        int          respDly;
        logic [1:0]  resp;
        int          nBeats;
        int          rspHold;
        logic [1:0]  expErr;
        logic [31:0] expRdata;
        logic [63:0] expWstrb;
    } vec_t;

    vec_t vecs[12];

    pci_mem_bridge #(.ID_VAL(ID), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycleStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Issues one command and plays the AXI slave until the bridge is back in IDLE.
    task automatic applyStimulus(input string tag, input vec_t v);
        int          c, cA, beatsSent, holdCnt, lane, expLat;
        bit          awSeen, wSeen, arSeen, reqDone, rspSeen, rspDone, respDone;
        bit          beatActive, timedOut, done, lanesOk;
        logic [31:0] lanes [16];
        logic [511:0] beatData;
        c = 0; cA = 0; beatsSent = 0; holdCnt = 0;
        awSeen = 0; wSeen = 0; arSeen = 0; reqDone = 0; rspSeen = 0; rspDone = 0;
        respDone = 0; beatActive = 0; done = 0;
        lane     = int'(v.addr[5:2]);
        timedOut = (v.expErr == 2'b11);
        expLat   = timedOut ? int'(TO) + 1 : v.respDly + v.nBeats;

        checkOutput({tag, " cmdReadyIdle"}, {busy, cmd_ready}, 2'b01);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cycleStep();
        cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
        c = 1;
        while (!done && c < 300) begin
            if (rspDone && cmd_ready) begin
                done = 1;
            end else begin
                checkOutput({tag, " busyFlags"}, {busy, cmd_ready}, 2'b10);
                m_awready = (c >= v.awDly);
                m_wready  = (c >= v.wDly);
                m_arready = (c >= v.awDly);
                if (!reqDone) begin
                    checkOutput({tag, " respReadyLow"}, {m_bready, m_rready}, 2'b00);
                    if (v.we) begin
                        checkOutput({tag, " awvalid"}, m_awvalid, !awSeen);
                        checkOutput({tag, " wvalid"}, m_wvalid, !wSeen);
                        if (m_awvalid && m_awready && !awSeen) begin
                            awSeen = 1;
                            checkOutput({tag, " awaddr"}, m_awaddr, v.addr & ~64'h3);
                            checkOutput({tag, " awfields"}, {m_awid, m_awlen, m_awsize}, {ID, 8'd0, 3'b010});
                        end
                        if (m_wvalid && m_wready && !wSeen) begin
                            wSeen = 1;
                            lanesOk = 1;
                            for (int i = 0; i < 16; i++)
                                if (m_wdata[32*i +: 32] !== v.wdata) lanesOk = 0;
                            checkOutput({tag, " wdata"}, lanesOk, 1);
                            checkOutput({tag, " wstrb"}, m_wstrb, v.expWstrb);
                            checkOutput({tag, " wfields"}, {m_wid, m_wlast}, {ID, 1'b1});
                        end
                    end else begin
                        checkOutput({tag, " arvalid"}, m_arvalid, 1);
                        if (m_arvalid && m_arready) begin
                            arSeen = 1;
                            checkOutput({tag, " araddr"}, m_araddr, v.addr & ~64'h3);
                            checkOutput({tag, " arfields"}, {m_arid, m_arlen, m_arsize}, {ID, 8'd0, 3'b010});
                        end
                    end
                    if (v.we ? (awSeen && wSeen) : arSeen) begin
                        reqDone = 1;
                        cA = c;
                    end
                end else if (c == cA + 1) begin
                    checkOutput({tag, " respReadyStart"}, v.we ? m_bready : m_rready, 1);
                end

                if (reqDone && !respDone && !beatActive && c >= cA + v.respDly) begin
                    beatActive = 1;
                    for (int i = 0; i < 16; i++) lanes[i] = $urandom;
                    if (beatsSent == v.nBeats - 1) begin
                        lanes[lane] = v.expRdata;
                        m_rresp = v.resp;
                        m_rlast = 1'b1;
                    end else begin
                        m_rresp = 2'b10;
                        m_rlast = 1'b0;
                    end
                    for (int i = 0; i < 16; i++) beatData[32*i +: 32] = lanes[i];
                    m_rdata = beatData;
                    m_bresp = v.resp;
                end
                m_bvalid = beatActive && v.we;
                m_rvalid = beatActive && !v.we;
                if (beatActive && (v.we ? m_bready : m_rready)) begin
                    beatActive = 0;
                    beatsSent++;
                    if (beatsSent == v.nBeats) respDone = 1;
                end

                rsp_ready = 1'b0;
                if (rspDone) begin
                    checkOutput({tag, " rspValidLow"}, rsp_valid, 0);
                end else if (rsp_valid) begin
                    if (!rspSeen) begin
                        rspSeen = 1;
                        checkOutput({tag, " rspLatency"}, c - cA, expLat);
                    end
                    checkOutput({tag, " rspErr"}, rsp_err, v.expErr);
                    if (!timedOut) checkOutput({tag, " rspRdata"}, rsp_rdata, v.expRdata);
                    rsp_ready = (holdCnt >= v.rspHold);
                    holdCnt++;
                    if (rsp_ready) rspDone = 1;
                end else if (rspSeen) begin
                    checkOutput({tag, " rspValidHeld"}, rsp_valid, 1);
                end
                cycleStep();
                c++;
            end
        end
        if (!done) checkOutput({tag, " completes"}, 0, 1);
        else checkOutput({tag, " drained"}, respDone, 1);
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        m_rlast = 0; rsp_ready = 0;
    endtask

    initial begin
        vec_t v;
        int   lane;

        vecs[0]  = '{1'b1, 64'h1004, 32'hDEADBEEF, 1, 1, 3, 2'b00, 1, 0, 2'b00, 32'h0, 64'h0000_0000_0000_00F0};
        vecs[1]  = '{1'b0, 64'h203C, 32'h0, 1, 1, 2, 2'b00, 1, 0, 2'b00, 32'h12345678, 64'h0};
        vecs[2]  = '{1'b1, 64'h8000_0001_0000_0040, 32'hA5A5_0001, 1, 4, 1, 2'b00, 1, 0, 2'b00, 32'h0, 64'h0000_0000_0000_000F};
        vecs[3]  = '{1'b1, 64'h3C, 32'h1111_2222, 2, 1, 2, 2'b10, 1, 0, 2'b01, 32'h0, 64'hF000_0000_0000_0000};
        vecs[4]  = '{1'b0, 64'h20, 32'h0, 3, 1, 1, 2'b11, 1, 0, 2'b01, 32'hCAFEF00D, 64'h0};
        vecs[5]  = '{1'b0, 64'h18, 32'h0, 1, 1, 2, 2'b00, 3, 0, 2'b00, 32'h0BADF00D, 64'h0};
        vecs[6]  = '{1'b1, 64'h1234_5678, 32'h7777_8888, 1, 2, 12, 2'b00, 1, 0, 2'b11, 32'h0, 64'h0F00_0000_0000_0000};
        vecs[7]  = '{1'b0, 64'h44, 32'h0, 1, 1, 9, 2'b00, 1, 1, 2'b11, 32'h0, 64'h0};
        vecs[8]  = '{1'b1, 64'h13, 32'h0102_0304, 1, 1, 8, 2'b00, 1, 0, 2'b00, 32'h0, 64'h0000_0000_000F_0000};
        vecs[9]  = '{1'b0, 64'h2C, 32'h0, 1, 1, 8, 2'b01, 1, 0, 2'b01, 32'h9ABC_DEF0, 64'h0};
        vecs[10] = '{1'b0, 64'h24, 32'h0, 1, 1, 1, 2'b00, 1, 5, 2'b00, 32'h55AA_33CC, 64'h0};
        vecs[11] = '{1'b1, 64'h2C, 32'hFEED_BEEF, 3, 2, 10, 2'b00, 1, 5, 2'b11, 32'h0, 64'h0000_F000_0000_0000};

        rstn = 1'b0;
        repeat (3) cycleStep();
        checkOutput("reset handshakes", {cmd_ready, busy, rsp_valid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 8'b1000_0000);
        checkOutput("reset response", {rsp_rdata, rsp_err}, 34'd0);
        rstn = 1'b1;
        cycleStep();

        for (int i = 0; i < 12; i++) applyStimulus($sformatf("v%0d", i), vecs[i]);

        // Reset while waiting for read data abandons the transaction outright.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 64'h100;
        cycleStep();
        cmd_valid = 1'b0;
        m_arready = 1'b1;
        cycleStep();
        m_arready = 1'b0;
        checkOutput("rst rreadyBefore", m_rready, 1);
        cycleStep();
        rstn = 1'b0;
        cycleStep();
        checkOutput("rst idleAfter", {cmd_ready, busy, m_rready, rsp_valid}, 4'b1000);
        rstn = 1'b1;
        cycleStep();
        checkOutput("rst stillIdle", {cmd_ready, busy, m_bready, m_rready}, 4'b1000);

        for (int i = 0; i < 40; i++) begin
            v.we      = 1'($urandom_range(0, 1));
            v.addr    = {$urandom, $urandom};
            v.wdata   = $urandom;
            v.awDly   = $urandom_range(1, 4);
            v.wDly    = $urandom_range(1, 4);
            v.respDly = $urandom_range(1, 12);
            v.resp    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            v.nBeats  = v.we ? 1 : $urandom_range(1, 3);
            if (v.respDly + v.nBeats - 1 > int'(TO)) v.nBeats = 1;
            v.rspHold = $urandom_range(0, 3);
            if (v.respDly > int'(TO)) v.expErr = 2'b11;
            else v.expErr = (v.resp == 2'b00) ? 2'b00 : 2'b01;
            v.expRdata = v.we ? 32'h0 : $urandom;
            lane = int'(v.addr[5:2]);
            v.expWstrb = '0;
            for (int b = 0; b < 64; b++) if (b / 4 == lane) v.expWstrb[b] = 1'b1;
            applyStimulus($sformatf("r%0d", i), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pci_mem_bridge.md
PCI_MEM_BRIDGE -- requirements
Module: pci_mem_bridge

Interface
REQ-001 SHALL have parameter ID_VAL, default 0, the AXI ID driven on every AW/AR/W.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, the response-wait limit in cycles (range 2..65535).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  64  byte address; bits [1:0] ignored
- cmd_wdata  in  32  write word
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read word; 0 for writes
- rsp_err  out  2  00 ok, 01 slave error, 11 timeout
- busy  out  1  state != IDLE
- m_aw{id,addr,len,size,valid} / m_awready  out/in  16,64,8,3,1 / 1  AXI write address
- m_w{id,data,strb,last,valid} / m_wready  out/in  16,512,64,1,1 / 1  AXI write data
- m_b{id,resp,valid} / m_bready  in/out  16,2,1 / 1  AXI write response
- m_ar{id,addr,len,size,valid} / m_arready  out/in  16,64,8,3,1 / 1  AXI read address
- m_r{id,data,resp,last,valid} / m_rready  in/out  16,512,2,1,1 / 1  AXI read data
REQ-004 SHALL drive the m_* ports as the pci port of the memory arbiter.

Function
REQ-005 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN.
REQ-006 SHALL assert cmd_ready only in IDLE; a cmd handshake captures we/addr/wdata into registers.
REQ-007 On handshake: SHALL enter WR_REQ if cmd_we=1, else RD_REQ.
REQ-008 SHALL drive AW and AR as: addr = {cmd_addr[63:2],2'b00}, len = 0, size = 3'b010, id = ID_VAL.
REQ-009 SHALL drive W as: wdata = captured word replicated 16 times, wstrb = 64'hF << (4*addr[5:2]), wlast = 1.
REQ-010 In WR_REQ SHALL assert awvalid and wvalid together. Each SHALL drop independently on its own handshake, tracked by flags aw_done and w_done. SHALL enter WR_RESP in the cycle both are done, including same-cycle handshakes.
REQ-011 In RD_REQ SHALL assert arvalid and enter RD_RESP on arready.
REQ-012 SHALL assert bready only in WR_RESP and DRAIN, and rready only in RD_RESP and DRAIN.
REQ-013 In WR_RESP, on bvalid SHALL enter RSP with rsp_rdata = 0 and rsp_err = (bresp != 0) ? 01 : 00.
REQ-014 In RD_RESP, on rvalid SHALL capture rsp_rdata = rdata[32*addr[5:2] +: 32] and rsp_err = (rresp != 0) ? 01 : 00. It SHALL enter RSP on the rlast beat and discard non-last beats.
REQ-015 SHALL keep a 16-bit wait counter:
- cleared on entry to WR_RESP or RD_RESP
- incremented each cycle in those states without a response
- on reaching TIMEOUT_CYC-1, SHALL enter RSP with rsp_err = 11 and set a drain flag.
REQ-016 A response arriving in the same cycle as the timeout SHALL win: normal completion, no drain.
REQ-017 In RSP SHALL hold rsp_valid=1 with data/err stable until rsp_ready. It SHALL then go to DRAIN if the drain flag is set, else to IDLE.
REQ-018 In DRAIN SHALL discard B (for a write) or R up to rlast (for a read), then clear the drain flag and go to IDLE. cmd_ready SHALL stay 0 throughout DRAIN.
REQ-019 SHALL ignore any B/R handshake outside the states granting bready/rready.
REQ-020 busy SHALL equal (state != IDLE), registered.

Reset
REQ-021 On rstn=0 at a clock edge, SHALL enter IDLE, clear aw_done/w_done/drain/counter, and zero rsp_rdata/rsp_err.
REQ-022 During and after reset, SHALL drive cmd_ready=1 (in IDLE) and deassert all of rsp_valid, awvalid, wvalid, arvalid, bready, rready.
REQ-023 Reset mid-transaction SHALL abandon the transaction without draining.

Verification
REQ-024 Write: addr 0x1004, wdata 0xDEADBEEF, awready=wready=1, bresp=0 after 3 cycles -> wstrb = 64'hF0, awaddr = 0x1004, rsp_err = 00, rsp_rdata = 0.
REQ-025 Read: addr 0x203C, rdata lane 15 = 0x12345678, rresp=0 -> rsp_rdata = 0x12345678, rsp_err = 00.
REQ-026 Split handshake: awready in cycle 1, wready in cycle 4 -> awvalid drops after cycle 1, wvalid held to cycle 4, bready first asserted in cycle 5.
REQ-027 Timeout: TIMEOUT_CYC=8, no bvalid -> rsp_err = 11 after 8 cycles in WR_RESP. Late bvalid then drains, followed by a return to IDLE with cmd_ready=1.
REQ-028 Backpressure: rsp_ready low for 5 cycles -> rsp_valid/data stable and cmd_ready = 0 throughout.
REQ-029 Reset in RD_RESP -> next cycle IDLE, rready = 0, rsp_valid = 0.
